// File: rtl/cpu_core_pkg.sv
// Shared definitions for the parametrised load/store core: opcodes, FSM states,
// instruction field layout and a decode helper.
package cpu_core_pkg;

  typedef enum logic [3:0] {
    OP_LOAD  = 4'd0,
    OP_STORE = 4'd1,
    OP_SET   = 4'd2,
    OP_LT    = 4'd3,
    OP_EQ    = 4'd4,
    OP_BEQ   = 4'd5,
    OP_BNEQ  = 4'd6,
    OP_ADD   = 4'd7,
    OP_SUB   = 4'd8,
    OP_SHL   = 4'd9,
    OP_SHR   = 4'd10,
    OP_AND   = 4'd11,
    OP_OR    = 4'd12,
    OP_INV   = 4'd13,
    OP_XOR   = 4'd14,
    OP_HALT  = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } state_e;

  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned FIELD_W  = 4;
  localparam int unsigned OP_LSB   = 12;
  localparam int unsigned DEST_LSB = 8;
  localparam int unsigned A1_LSB   = 4;
  localparam int unsigned A2_LSB   = 0;

  typedef struct packed {
    opcode_e    op;
    logic [3:0] dest;
    logic [3:0] a1;
    logic [3:0] a2;
  } instr_t;

  function automatic instr_t decode(input logic [INSTR_W-1:0] raw);
    instr_t d;
    d.op   = opcode_e'(raw[OP_LSB +: FIELD_W]);
    d.dest = raw[DEST_LSB +: FIELD_W];
    d.a1   = raw[A1_LSB +: FIELD_W];
    d.a2   = raw[A2_LSB +: FIELD_W];
    return d;
  endfunction

endpackage

// File: rtl/cpu_core_alu.sv
// Combinational ALU for the core: compare, arithmetic, shift and bitwise ops.
module cpu_core_alu
  import cpu_core_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  opcode_e           i_op,
  input  logic [DATA_W-1:0] i_ra,
  input  logic [DATA_W-1:0] i_rb,
  output logic [DATA_W-1:0] o_result
);

  localparam logic [DATA_W-1:0] SH_LIMIT = DATA_W'(DATA_W);

  logic w_sh_oob;

  // Select the result for the current opcode; non-ALU opcodes yield zero
  always_comb begin
    o_result = '0;
    w_sh_oob = (i_rb >= SH_LIMIT);
    case (i_op)
      OP_LT:   o_result = DATA_W'(i_ra < i_rb);
      OP_EQ:   o_result = DATA_W'(i_ra == i_rb);
      OP_ADD:  o_result = i_ra + i_rb;
      OP_SUB:  o_result = i_ra - i_rb;
      OP_SHL:  o_result = w_sh_oob ? '0 : (i_ra << i_rb);
      OP_SHR:  o_result = w_sh_oob ? '0 : (i_ra >> i_rb);
      OP_AND:  o_result = i_ra & i_rb;
      OP_OR:   o_result = i_ra | i_rb;
      OP_INV:  o_result = ~i_ra;
      OP_XOR:  o_result = i_ra ^ i_rb;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/cpu_core_param.sv
// Multi-cycle 16-register load/store core. r0 is the PC; instructions come
// from a synchronous ROM, data goes through a req/ack bus with wait states.
module cpu_core_param
  import cpu_core_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PC_W   = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [15:0]       imem_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              halted
);

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);
  localparam logic [DATA_W-1:0] TWO = DATA_W'(2);

  state_e            r_state;
  state_e            w_next;
  logic [DATA_W-1:0] r_regs [16];
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_ld_dest;

  instr_t            w_ins;
  logic [DATA_W-1:0] w_pc;
  logic [DATA_W-1:0] w_ra;
  logic [DATA_W-1:0] w_rb;
  logic [DATA_W-1:0] w_rd;
  logic [DATA_W-1:0] w_k;
  logic [DATA_W-1:0] w_alu;
  logic [DATA_W-1:0] w_result;
  logic              w_writes;
  logic              w_taken;

  assign w_ins     = decode(imem_data);
  assign w_pc      = r_regs[0];
  assign w_ra      = r_regs[w_ins.a1];
  assign w_rb      = r_regs[w_ins.a2];
  assign w_rd      = r_regs[w_ins.dest];
  assign w_k       = DATA_W'({w_ins.a1, w_ins.a2});
  assign imem_addr = PC_W'(w_pc);

  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;

  cpu_core_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .i_op    (w_ins.op),
    .i_ra    (w_ra),
    .i_rb    (w_rb),
    .o_result(w_alu)
  );

  // Classify the decoded instruction: result value, writeback and branch taken
  always_comb begin
    w_writes = 1'b0;
    w_taken  = 1'b0;
    w_result = w_alu;
    case (w_ins.op)
      OP_SET: begin
        w_writes = 1'b1;
        w_result = w_k;
      end
      OP_LT, OP_EQ, OP_ADD, OP_SUB, OP_SHL, OP_SHR,
      OP_AND, OP_OR, OP_INV, OP_XOR: w_writes = 1'b1;
      OP_BEQ:  w_taken = (w_rd == w_k);
      OP_BNEQ: w_taken = (w_rd != w_k);
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_FETCH;
    else      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH: w_next = ST_EXEC;
      ST_EXEC: begin
        case (w_ins.op)
          OP_HALT:           w_next = ST_HALT;
          OP_LOAD, OP_STORE: w_next = ST_MEM;
          default:           w_next = ST_FETCH;
        endcase
      end
      ST_MEM:   if (dmem_ack) w_next = ST_FETCH;
      ST_HALT:  w_next = ST_HALT;
      default:  w_next = ST_FETCH;
    endcase
  end

  // State-decoded outputs; req follows the state so reset drops it at once
  always_comb begin
    dmem_req = (r_state == ST_MEM);
    halted   = (r_state == ST_HALT);
  end

  // Register file, PC and bus request registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_regs    <= '{default: '0};
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_ld_dest <= '0;
    end else begin
      case (r_state)
        ST_EXEC: begin
          case (w_ins.op)
            OP_LOAD, OP_STORE: begin
              r_we      <= (w_ins.op == OP_STORE);
              r_addr    <= ADDR_W'(w_ra + DATA_W'(w_ins.a2));
              r_wdata   <= w_rd;
              r_ld_dest <= w_ins.dest;
            end
            OP_HALT: ;
            default: begin
              // The dest write is issued after the PC update so that a
              // result aimed at r0 overrides the increment (jump).
              r_regs[0] <= w_pc + (w_taken ? TWO : ONE);
              if (w_writes) r_regs[w_ins.dest] <= w_result;
            end
          endcase
        end
        ST_MEM: begin
          if (dmem_ack) begin
            r_regs[0] <= w_pc + ONE;
            if (!r_we) r_regs[r_ld_dest] <= dmem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_core_param.sv
// Directed self-checking bench for cpu_core_param (8-bit and 16-bit builds).
module tb_cpu_core_param;

  logic clk = 1'b0;
  logic rst;

  // 8-bit core
  logic [7:0]  a_imem_addr;
  logic [15:0] a_imem_data;
  logic        a_req, a_we, a_ack, a_halted;
  logic [7:0]  a_addr, a_wdata, a_rdata;
  logic [15:0] rom_a [256];

  // 16-bit core
  logic [7:0]  b_imem_addr;
  logic [15:0] b_imem_data;
  logic        b_req, b_we, b_ack, b_halted;
  logic [7:0]  b_addr;
  logic [15:0] b_wdata, b_rdata;
  logic [15:0] rom_b [256];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  always @(posedge clk) a_imem_data <= rom_a[a_imem_addr];
  always @(posedge clk) b_imem_data <= rom_b[b_imem_addr];

  cpu_core_param #(.DATA_W(8), .PC_W(8), .ADDR_W(8)) dut_a (
    .clk(clk), .rst(rst),
    .imem_addr(a_imem_addr), .imem_data(a_imem_data),
    .dmem_req(a_req), .dmem_we(a_we), .dmem_addr(a_addr),
    .dmem_wdata(a_wdata), .dmem_rdata(a_rdata), .dmem_ack(a_ack),
    .halted(a_halted)
  );

  cpu_core_param #(.DATA_W(16), .PC_W(8), .ADDR_W(8)) dut_b (
    .clk(clk), .rst(rst),
    .imem_addr(b_imem_addr), .imem_data(b_imem_data),
    .dmem_req(b_req), .dmem_we(b_we), .dmem_addr(b_addr),
    .dmem_wdata(b_wdata), .dmem_rdata(b_rdata), .dmem_ack(b_ack),
    .halted(b_halted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_roms();
    for (int i = 0; i < 256; i++) begin
      rom_a[i] = 16'h0000;
      rom_b[i] = 16'h0000;
    end
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    a_ack = 1'b0;
    step(1);
    rst = 1'b1;
  endtask

  initial begin
    rst     = 1'b0;
    a_ack   = 1'b0;
    a_rdata = 8'h00;
    b_ack   = 1'b0;
    b_rdata = 16'h0000;
    clear_roms();

    // Reset state
    step(1);
    check("rst_req",    32'(a_req),       32'h0);
    check("rst_we",     32'(a_we),        32'h0);
    check("rst_addr",   32'(a_addr),      32'h0);
    check("rst_wdata",  32'(a_wdata),     32'h0);
    check("rst_halted", 32'(a_halted),    32'h0);
    check("rst_pc",     32'(a_imem_addr), 32'h0);

    // SET/SET/SUB/HALT: halted after 8 cycles
    rom_a[0] = 16'h2105;
    rom_a[1] = 16'h2203;
    rom_a[2] = 16'h8312;
    rom_a[3] = 16'hF000;
    do_reset();
    step(7);
    check("t1_not_yet_halted", 32'(a_halted), 32'h0);
    step(1);
    check("t1_halted", 32'(a_halted),          32'h1);
    check("t1_r3",     32'(dut_a.r_regs[3]),   32'h2);
    check("t1_pc",     32'(a_imem_addr),       32'h3);
    step(3);
    check("t1_pc_frozen", 32'(a_imem_addr),    32'h3);

    // STORE r1,[r2+1] with four wait cycles
    clear_roms();
    rom_a[0] = 16'h21A5;
    rom_a[1] = 16'h2210;
    rom_a[2] = 16'h1121;
    rom_a[3] = 16'hF000;
    do_reset();
    step(5);
    check("t2_req_exec", 32'(a_req), 32'h0);
    step(1);
    check("t2_req",   32'(a_req),   32'h1);
    check("t2_we",    32'(a_we),    32'h1);
    check("t2_addr",  32'(a_addr),  32'h11);
    check("t2_wdata", 32'(a_wdata), 32'hA5);
    for (int w = 0; w < 4; w++) begin
      step(1);
      check("t2_req_hold",   32'(a_req),   32'h1);
      check("t2_addr_hold",  32'(a_addr),  32'h11);
      check("t2_wdata_hold", 32'(a_wdata), 32'hA5);
    end
    a_ack = 1'b1;
    step(1);
    a_ack = 1'b0;
    check("t2_req_done", 32'(a_req),       32'h0);
    check("t2_pc",       32'(a_imem_addr), 32'h3);
    step(2);
    check("t2_halted",   32'(a_halted),    32'h1);

    // Reset during MEM: req drops immediately, registers cleared, restart at 0
    do_reset();
    step(6);
    check("t6_req_mem", 32'(a_req), 32'h1);
    rst = 1'b0;
    #1;
    check("t6_req_async", 32'(a_req),          32'h0);
    check("t6_r1",        32'(dut_a.r_regs[1]), 32'h0);
    check("t6_r2",        32'(dut_a.r_regs[2]), 32'h0);
    check("t6_addr",      32'(a_addr),          32'h0);
    check("t6_pc",        32'(a_imem_addr),     32'h0);
    step(1);
    rst = 1'b1;
    step(2);
    check("t6_resume_r1", 32'(dut_a.r_regs[1]), 32'hA5);
    check("t6_resume_pc", 32'(a_imem_addr),     32'h1);

    // LOAD r4,[r0+0] with ack held high (ignored outside MEM), then LOAD to r0
    clear_roms();
    rom_a[0]     = 16'h0400;
    rom_a[1]     = 16'h0005;
    rom_a[8'h40] = 16'hF000;
    do_reset();
    a_ack   = 1'b1;
    a_rdata = 8'h3C;
    step(2);
    check("t3_req",  32'(a_req),  32'h1);
    check("t3_we",   32'(a_we),   32'h0);
    check("t3_addr", 32'(a_addr), 32'h0);
    step(1);
    check("t3_req_done", 32'(a_req),           32'h0);
    check("t3_r4",       32'(dut_a.r_regs[4]), 32'h3C);
    check("t3_pc",       32'(a_imem_addr),     32'h1);
    a_rdata = 8'h40;
    step(2);
    check("t3_addr2", 32'(a_addr), 32'h06);
    step(1);
    check("t3_jump_pc", 32'(a_imem_addr), 32'h40);
    a_ack = 1'b0;
    step(2);
    check("t3_halted", 32'(a_halted), 32'h1);

    // Branches and SET r0
    clear_roms();
    rom_a[0]     = 16'h2105;
    rom_a[1]     = 16'h5105;
    rom_a[2]     = 16'h25EE;
    rom_a[3]     = 16'h2106;
    rom_a[4]     = 16'h5105;
    rom_a[5]     = 16'h6105;
    rom_a[6]     = 16'h25EE;
    rom_a[7]     = 16'h2020;
    rom_a[8'h20] = 16'hF000;
    do_reset();
    step(4);
    check("t4_beq_taken", 32'(a_imem_addr), 32'h3);
    step(4);
    check("t4_beq_not_taken", 32'(a_imem_addr), 32'h5);
    step(2);
    check("t4_bneq_taken", 32'(a_imem_addr), 32'h7);
    step(2);
    check("t4_set_r0", 32'(a_imem_addr), 32'h20);
    step(2);
    check("t4_halted",  32'(a_halted),          32'h1);
    check("t4_skipped", 32'(dut_a.r_regs[5]),   32'h0);

    // ALU ops and same-register source/dest
    clear_roms();
    rom_a[0] = 16'h210F;
    rom_a[1] = 16'h2203;
    rom_a[2] = 16'h3321;
    rom_a[3] = 16'h4411;
    rom_a[4] = 16'hA512;
    rom_a[5] = 16'hE612;
    rom_a[6] = 16'hD710;
    rom_a[7] = 16'h7111;
    rom_a[8] = 16'hF000;
    do_reset();
    step(16);
    check("t7_lt",  32'(dut_a.r_regs[3]), 32'h01);
    check("t7_eq",  32'(dut_a.r_regs[4]), 32'h01);
    check("t7_shr", 32'(dut_a.r_regs[5]), 32'h01);
    check("t7_xor", 32'(dut_a.r_regs[6]), 32'h0C);
    check("t7_inv", 32'(dut_a.r_regs[7]), 32'hF0);
    check("t7_add_self", 32'(dut_a.r_regs[1]), 32'h1E);
    step(2);
    check("t7_halted", 32'(a_halted), 32'h1);

    // 16-bit build: SHL by 16, ADD wrap, PC 0xFFFF and wrap to 0
    clear_roms();
    rom_b[0]     = 16'h23AB;
    rom_b[1]     = 16'h2110;
    rom_b[2]     = 16'h2401;
    rom_b[3]     = 16'h8254;
    rom_b[4]     = 16'h9321;
    rom_b[5]     = 16'h7224;
    rom_b[6]     = 16'h8054;
    rom_b[8'hFF] = 16'h2777;
    do_reset();
    step(14);
    check("t5_shl16",   32'(dut_b.r_regs[3]), 32'h0);
    check("t5_add_wrap", 32'(dut_b.r_regs[2]), 32'h0);
    check("t5_pc_full", 32'(dut_b.r_regs[0]), 32'hFFFF);
    check("t5_imem_lo", 32'(b_imem_addr),     32'hFF);
    step(2);
    check("t5_pc_wrap", 32'(dut_b.r_regs[0]), 32'h0);
    check("t5_r7",      32'(dut_b.r_regs[7]), 32'h77);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
